// File: rtl/uart_pkg.sv
// Shared types and constants for the uart_ctrl peripheral.
package uart_pkg;

   typedef enum logic [1:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP,
      RX_WAIT_HIGH
   } rx_state_t;

   // Bit positions inside uart_status.
   localparam int ST_TX_BUSY  = 0;
   localparam int ST_RX_VALID = 1;
   localparam int ST_RX_OVR   = 2;
   localparam int ST_RX_FERR  = 3;

endpackage

// File: rtl/uart_rx.sv
// 8N1 receiver: 2-FF synchroniser, mid-bit sampling FSM, shift register.
// Emits a one-cycle done pulse with the byte, or a one-cycle frame-error pulse.
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rstb_in,
   input  logic       rx_in,
   output logic       done_o,
   output logic [7:0] data_o,
   output logic       ferr_o
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2);

   rx_state_t     state_q, state_d;
   logic          sync1_q, sync1_d;
   logic          sync2_q, sync2_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bit_q, bit_d;
   logic [7:0]    shift_q, shift_d;
   logic          done_q, done_d;
   logic          ferr_q, ferr_d;
   logic          rx_s;

   assign rx_s   = sync2_q;
   assign done_o = done_q;
   assign ferr_o = ferr_q;
   assign data_o = shift_q;

   // Next-state logic: counter counts down to zero, sample taken at zero.
   always_comb begin
      state_d = state_q;
      sync1_d = rx_in;
      sync2_d = sync1_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      done_d  = 1'b0;
      ferr_d  = 1'b0;
      case (state_q)
         RX_IDLE: begin
            if (!rx_s) begin
               state_d = RX_START;
               cnt_d   = CNT_HALF;
            end
         end
         RX_START: begin
            if (cnt_q == '0) begin
               if (!rx_s) begin
                  state_d = RX_DATA;
                  cnt_d   = CNT_FULL;
                  bit_d   = 3'd0;
               end else begin
                  // Line returned high before mid-start-bit: a glitch.
                  state_d = RX_IDLE;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_DATA: begin
            if (cnt_q == '0) begin
               shift_d = {rx_s, shift_q[7:1]};
               cnt_d   = CNT_FULL;
               if (bit_q == 3'd7) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_STOP: begin
            if (cnt_q == '0) begin
               if (rx_s) begin
                  done_d  = 1'b1;
                  state_d = RX_IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = RX_WAIT_HIGH;
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         RX_WAIT_HIGH: begin
            if (rx_s) begin
               state_d = RX_IDLE;
            end
         end
         default: state_d = RX_IDLE;
      endcase
   end

   // State register; synchroniser resets to the idle-high line level.
   always_ff @(posedge clk or negedge rstb_in) begin
      if (!rstb_in) begin
         state_q <= RX_IDLE;
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         cnt_q   <= '0;
         bit_q   <= 3'd0;
         shift_q <= 8'h00;
         done_q  <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         done_q  <= done_d;
         ferr_q  <= ferr_d;
      end
   end

endmodule

// File: rtl/uart_ctrl.sv
// UART peripheral top: TX FSM, RX holding register and sticky error flags.
// Strobes (tx_wr, rx_rd, err_clr) are single-cycle pulses from the register
// bus with no backpressure; a tx_wr while busy is dropped.
module uart_ctrl
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       rstb_in,
   input  logic       tx_wr,
   input  logic [7:0] tx_data,
   input  logic       rx_rd,
   input  logic       err_clr,
   input  logic       uart_rx,
   output logic       uart_tx,
   output logic [7:0] uart_status,
   output logic [7:0] uart_rcvd_byte
);

   localparam int            CW       = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   tx_state_t     tx_state_q, tx_state_d;
   logic [CW-1:0] tx_cnt_q, tx_cnt_d;
   logic [2:0]    tx_bit_q, tx_bit_d;
   logic [7:0]    tx_shift_q, tx_shift_d;
   logic          uart_tx_q, uart_tx_d;

   logic          rx_valid_q, rx_valid_d;
   logic          rx_ovr_q, rx_ovr_d;
   logic          rx_ferr_q, rx_ferr_d;
   logic [7:0]    rcvd_q, rcvd_d;

   logic          rx_done;
   logic          rx_ferr;
   logic [7:0]    rx_byte;
   logic          tx_busy;

   uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk     (clk),
      .rstb_in (rstb_in),
      .rx_in   (uart_rx),
      .done_o  (rx_done),
      .data_o  (rx_byte),
      .ferr_o  (rx_ferr)
   );

   assign tx_busy        = (tx_state_q != TX_IDLE);
   assign uart_tx        = uart_tx_q;
   assign uart_rcvd_byte = rcvd_q;

   always_comb begin
      uart_status              = 8'h00;
      uart_status[ST_TX_BUSY]  = tx_busy;
      uart_status[ST_RX_VALID] = rx_valid_q;
      uart_status[ST_RX_OVR]   = rx_ovr_q;
      uart_status[ST_RX_FERR]  = rx_ferr_q;
   end

   // TX next-state: each state holds CLKS_PER_BIT cycles per bit; the serial
   // output is computed from the next state so uart_tx comes from a flop.
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      case (tx_state_q)
         TX_IDLE: begin
            if (tx_wr) begin
               tx_shift_d = tx_data;
               tx_cnt_d   = '0;
               tx_state_d = TX_START;
            end
         end
         TX_START: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_bit_d   = 3'd0;
               tx_state_d = TX_DATA;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_DATA: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d = '0;
               if (tx_bit_q == 3'd7) begin
                  tx_state_d = TX_STOP;
               end else begin
                  tx_bit_d   = tx_bit_q + 1'b1;
                  tx_shift_d = {1'b0, tx_shift_q[7:1]};
               end
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         TX_STOP: begin
            if (tx_cnt_q == CNT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = TX_IDLE;
            end else begin
               tx_cnt_d = tx_cnt_q + 1'b1;
            end
         end
         default: tx_state_d = TX_IDLE;
      endcase
      case (tx_state_d)
         TX_START: uart_tx_d = 1'b0;
         TX_DATA:  uart_tx_d = tx_shift_d[0];
         default:  uart_tx_d = 1'b1;
      endcase
   end

   // RX holding register and sticky flags: a store beats rx_rd, a set beats err_clr.
   always_comb begin
      rx_valid_d = rx_valid_q;
      rx_ovr_d   = rx_ovr_q;
      rx_ferr_d  = rx_ferr_q;
      rcvd_d     = rcvd_q;
      if (err_clr) begin
         rx_ovr_d  = 1'b0;
         rx_ferr_d = 1'b0;
      end
      if (rx_done) begin
         rcvd_d     = rx_byte;
         rx_valid_d = 1'b1;
         if (rx_valid_q && !rx_rd) begin
            rx_ovr_d = 1'b1;
         end
      end else if (rx_rd) begin
         rx_valid_d = 1'b0;
      end
      if (rx_ferr) begin
         rx_ferr_d = 1'b1;
      end
   end

   // Register update; uart_tx resets high so a mid-frame reset idles the line at once.
   always_ff @(posedge clk or negedge rstb_in) begin
      if (!rstb_in) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= 3'd0;
         tx_shift_q <= 8'h00;
         uart_tx_q  <= 1'b1;
         rx_valid_q <= 1'b0;
         rx_ovr_q   <= 1'b0;
         rx_ferr_q  <= 1'b0;
         rcvd_q     <= 8'h00;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         uart_tx_q  <= uart_tx_d;
         rx_valid_q <= rx_valid_d;
         rx_ovr_q   <= rx_ovr_d;
         rx_ferr_q  <= rx_ferr_d;
         rcvd_q     <= rcvd_d;
      end
   end

endmodule

// File: tb/tb_uart_ctrl.sv
// Bench for uart_ctrl with CLKS_PER_BIT=8. Stimulus pushes expected TX frames
// and expected RX register updates into queues; two monitors pop and compare.
module tb_uart_ctrl;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rstb_in = 1'b1;
   logic       tx_wr = 1'b0;
   logic [7:0] tx_data = 8'h00;
   logic       rx_rd = 1'b0;
   logic       err_clr = 1'b0;
   logic       rx_line = 1'b1;
   logic       loop_en = 1'b0;
   logic       rx_dut;
   logic       uart_tx;
   logic [7:0] uart_status;
   logic [7:0] uart_rcvd_byte;
   logic       rst_done = 1'b0;

   int n_checks = 0;
   int n_errors = 0;

   // {ferr, ovr, valid, byte} expected after each RX-visible register update.
   logic [10:0] rx_exp_q[$];
   logic [7:0]  tx_exp_q[$];

   assign rx_dut = loop_en ? uart_tx : rx_line;

   uart_ctrl #(.CLKS_PER_BIT(CPB)) dut (
      .clk            (clk),
      .rstb_in        (rstb_in),
      .tx_wr          (tx_wr),
      .tx_data        (tx_data),
      .rx_rd          (rx_rd),
      .err_clr        (err_clr),
      .uart_rx        (rx_dut),
      .uart_tx        (uart_tx),
      .uart_status    (uart_status),
      .uart_rcvd_byte (uart_rcvd_byte)
   );

   // Clock and watchdog.
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Driver tasks (all start and end on a falling clock edge).
   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic drive_bit(input logic v);
      rx_line = v;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic send_rx(input logic [7:0] b, input logic stop_bit);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(b[i]);
      drive_bit(stop_bit);
      rx_line = 1'b1;
   endtask

   task automatic pulse_tx(input logic [7:0] b);
      tx_data = b;
      tx_wr   = 1'b1;
      @(negedge clk);
      tx_wr   = 1'b0;
   endtask

   task automatic pulse_rd(input logic [10:0] exp_after);
      rx_exp_q.push_back(exp_after);
      rx_rd = 1'b1;
      @(negedge clk);
      rx_rd = 1'b0;
   endtask

   task automatic pulse_clr(input logic [10:0] exp_after);
      rx_exp_q.push_back(exp_after);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   // TX monitor: on a start bit, check every cycle of all 10 bit slots and the busy fall.
   initial begin : tx_mon
      logic [9:0]  frame;
      logic [31:0] act;
      wait (rst_done);
      forever begin
         @(negedge clk);
         if (uart_tx === 1'b0) begin
            if (tx_exp_q.size() == 0) begin
               check("tx_unexpected_frame", 32'd1, 32'd0);
               frame = {1'b1, 8'h00, 1'b0};
            end else begin
               frame = {1'b1, tx_exp_q.pop_front(), 1'b0};
            end
            for (int s = 0; s < 10; s++) begin
               act = {30'd0, 1'b1, frame[s]};
               for (int c = 0; c < CPB; c++) begin
                  if (s != 0 || c != 0) @(negedge clk);
                  if ({uart_status[0], uart_tx} !== {1'b1, frame[s]} && act == {30'd0, 1'b1, frame[s]})
                     act = {30'd0, uart_status[0], uart_tx};
               end
               check($sformatf("tx_slot%0d busy/line", s), act, {30'd0, 1'b1, frame[s]});
            end
            @(negedge clk);
            check("tx_busy_fall busy/line", {30'd0, uart_status[0], uart_tx}, 32'd1);
         end
      end
   end

   // RX monitor: every change of {ferr, ovr, valid, byte} must match the next expected entry.
   initial begin : rx_mon
      logic [10:0] prev, cur, exp;
      wait (rst_done);
      prev = {uart_status[3:1], uart_rcvd_byte};
      forever begin
         @(negedge clk);
         cur = {uart_status[3:1], uart_rcvd_byte};
         if (cur !== prev) begin
            if (rx_exp_q.size() == 0) begin
               check("rx_unexpected_change", {21'd0, cur}, {21'd0, prev});
            end else begin
               exp = rx_exp_q.pop_front();
               check("rx_update", {21'd0, cur}, {21'd0, exp});
            end
            prev = cur;
         end
      end
   end

   // Directed sequence.
   initial begin : stim
      #3 rstb_in = 1'b0;
      repeat (4) @(negedge clk);
      check("reset uart_tx", {31'd0, uart_tx}, 32'd1);
      check("reset uart_status", {24'd0, uart_status}, 32'h00);
      check("reset uart_rcvd_byte", {24'd0, uart_rcvd_byte}, 32'h00);
      rstb_in = 1'b1;
      @(negedge clk);
      rst_done = 1'b1;
      idle(2);

      // TX 0xA5; a second write at cycle 40 must be dropped.
      tx_exp_q.push_back(8'hA5);
      pulse_tx(8'hA5);
      idle(39);
      pulse_tx(8'h3C);
      idle(60);

      // Single good RX frame, then read.
      rx_exp_q.push_back({3'b001, 8'h5A});
      send_rx(8'h5A, 1'b1);
      idle(12);
      check("status after 0x5A", {24'd0, uart_status}, 32'h02);
      pulse_rd({3'b000, 8'h5A});
      check("status after rx_rd", {24'd0, uart_status}, 32'h00);

      // Overrun: two frames without a read, then clear errors.
      rx_exp_q.push_back({3'b001, 8'h11});
      send_rx(8'h11, 1'b1);
      idle(12);
      rx_exp_q.push_back({3'b011, 8'h22});
      send_rx(8'h22, 1'b1);
      idle(12);
      check("status after overrun", {24'd0, uart_status}, 32'h06);
      check("byte after overrun", {24'd0, uart_rcvd_byte}, 32'h22);
      pulse_clr({3'b001, 8'h22});
      check("status after err_clr", {24'd0, uart_status}, 32'h02);
      idle(2);
      pulse_rd({3'b000, 8'h22});
      idle(2);

      // Framing error with the line held low, then a good frame.
      rx_exp_q.push_back({3'b100, 8'h22});
      send_rx(8'h33, 1'b0);
      rx_line = 1'b0;
      idle(50);
      rx_line = 1'b1;
      idle(10);
      rx_exp_q.push_back({3'b101, 8'h7E});
      send_rx(8'h7E, 1'b1);
      idle(12);
      check("status after frame error + 0x7E", {24'd0, uart_status}, 32'h0A);

      // Three-cycle glitch must leave everything unchanged.
      rx_line = 1'b0;
      idle(3);
      rx_line = 1'b1;
      idle(30);
      check("status after glitch", {24'd0, uart_status}, 32'h0A);
      check("byte after glitch", {24'd0, uart_rcvd_byte}, 32'h7E);

      // Loopback 0xC3 through the TX path into the RX path.
      pulse_rd({3'b100, 8'h7E});
      idle(2);
      loop_en = 1'b1;
      tx_exp_q.push_back(8'hC3);
      rx_exp_q.push_back({3'b101, 8'hC3});
      pulse_tx(8'hC3);
      idle(100);
      loop_en = 1'b0;
      check("loopback byte", {24'd0, uart_rcvd_byte}, 32'hC3);
      idle(5);

      check("rx expected updates outstanding", rx_exp_q.size(), 32'd0);
      check("tx expected frames outstanding", tx_exp_q.size(), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Byte-wide UART transmitter/receiver peripheral that sits directly downstream of the SoC register file. It takes TX bytes and read/clear strobes from the register-bus fields and drives the `uart_status` / `uart_rcvd_byte` fields back into it, replacing today's tied-off zeros. It is an 8N1 UART with a fixed, parameterised bit period, a one-byte RX holding register and sticky error flags.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clk cycles per UART bit (50 MHz / 115200). Must be ≥ 4.

Ports:
- `clk`  in  1  system clock.
- `rstb_in`  in  1  reset, asynchronous, active-low.
- `tx_wr`  in  1  one-cycle pulse: load `tx_data` and start a frame.
- `tx_data`  in  8  byte to send, sampled when `tx_wr`=1.
- `rx_rd`  in  1  one-cycle pulse: CPU consumed `rcvd_byte`; clears `rx_valid`.
- `err_clr`  in  1  one-cycle pulse: clears `rx_overrun` and `rx_frame_err`.
- `uart_rx`  in  1  asynchronous serial input, idle high.
- `uart_tx`  out  1  serial output, idle high.
- `uart_status`  out  8  bit0 `tx_busy`, bit1 `rx_valid`, bit2 `rx_overrun`, bit3 `rx_frame_err`, bits7:4 = 0.
- `uart_rcvd_byte`  out  8  last good received byte.

## Operation
- Reset values: `uart_tx`=1, `uart_status`=0, `uart_rcvd_byte`=0. Both FSMs go to IDLE and all counters clear.
- TX FSM, states IDLE → START → DATA → STOP → IDLE.
  - In IDLE, `tx_wr` latches `tx_data`.
  - START drives 0. DATA drives bits LSB first, 8 bits. STOP drives 1.
  - Each state lasts CLKS_PER_BIT cycles per bit.
  - `tx_wr` while `tx_busy`=1 is ignored and the byte is dropped.
- RX path:
  - `uart_rx` passes through a 2-FF synchroniser. All RX logic uses the synchronised value.
  - RX FSM states are IDLE, START, DATA, STOP, WAIT_HIGH.
  - IDLE: when the synchronised line is 0, go to START and load the counter with CLKS_PER_BIT/2 (integer division).
  - START: at counter expiry, if the line is still 0 go to DATA; otherwise it was a glitch, so return to IDLE with no flag change.
  - DATA: sample each bit every CLKS_PER_BIT cycles, LSB first, 8 samples.
  - STOP: sample after CLKS_PER_BIT.
    - Sample = 1: write the byte to `uart_rcvd_byte`. If `rx_valid` was already 1 and no `rx_rd` arrives that cycle, set `rx_overrun`, and the new byte overwrites the old one. Then set `rx_valid`=1 and go to IDLE.
    - Sample = 0: set `rx_frame_err`, discard the byte, leave `uart_rcvd_byte`/`rx_valid` unchanged, and go to WAIT_HIGH.
  - WAIT_HIGH: stay until the line is 1, then go to IDLE. This covers a break or line held low.
- Simultaneous events:
  - `rx_rd` in the same cycle as a good-byte store: the store wins, `rx_valid` stays 1 and `rx_overrun` is not set.
  - `err_clr` in the same cycle as a new error: the set wins.
- The TX and RX paths are fully independent, so full duplex works.

## Timing
- `tx_wr` at cycle 0:
  - `tx_busy`=1 and `uart_tx`=0 from cycle 1.
  - Data bit k starts at cycle 1+(k+1)·CLKS_PER_BIT.
  - Stop bit starts at 1+9·CLKS_PER_BIT.
  - `tx_busy` falls at cycle 1+10·CLKS_PER_BIT.
  - A new `tx_wr` is accepted in that same cycle.
- RX latency: from the falling edge on `uart_rx`, the synchroniser adds 2 cycles. `rx_valid` rises about 2 + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles after the start edge, i.e. mid-stop-bit.
- The `rx_rd` effect is visible on `uart_status` the next cycle. The `err_clr` effect is also visible the next cycle.
- All outputs are registered. No combinational path runs from inputs to outputs.
- `rstb_in` asserted mid-frame: `uart_tx` goes to 1 immediately (asynchronously), any partial RX byte is lost and no flags are set.

## Structure
- `uart_pkg`:
  - `tx_state_t` and `rx_state_t` enums.
  - Status bit index constants: `ST_TX_BUSY`=0, `ST_RX_VALID`=1, `ST_RX_OVR`=2, `ST_RX_FERR`=3.
- Sub-module `uart_rx` contains the synchroniser, RX FSM, bit counter and shift register. It outputs a byte-done pulse, the data, and a frame-error pulse.
- The top level holds the TX FSM, the holding register and the flags.
- The SoC top replaces the tied-off status and received-byte assigns with `uart_ctrl`. The regfile decodes `tx_wr` as a write to address 0, byte lane 1, with data bits 15:8.

## Test plan
Run all scenarios with CLKS_PER_BIT=8.
- Reset: hold `rstb_in`=0 → `uart_tx`=1, `uart_status`=0x00, `uart_rcvd_byte`=0x00.
- `tx_wr` with 0xA5 → `uart_tx` shows 0, then 1,0,1,0,0,1,0,1, then 1, each held 8 cycles. `tx_busy` is high for exactly 80 cycles. A second `tx_wr` of 0x3C at cycle 40 is dropped.
- Drive an RX frame 0x5A → `uart_rcvd_byte`=0x5A and `uart_status`=0x02. Pulse `rx_rd` → `uart_status`=0x00 the next cycle.
- Send two frames 0x11 then 0x22 with no `rx_rd` → `uart_rcvd_byte`=0x22 and `uart_status`=0x06. Pulse `err_clr` → `uart_status`=0x02.
- RX frame with stop bit 0, then line held low 50 cycles, then high, then frame 0x7E → `rx_frame_err` set, no byte stored until 0x7E, final `uart_status`=0x0A.
- 3-cycle low glitch on `uart_rx` → no state change. Loopback of `uart_tx` to `uart_rx` with 0xC3 → received 0xC3.
